// File: rtl/seg7_pkg.sv
// Shared segment patterns, FSM state type and the decimal-range helper
// for the HEX display driver.
package seg7_pkg;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } seg7_state_e;

  // 10^n, evaluated at elaboration for the overflow bound
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/seg7_bin_display_if.sv
// Request/result bundle between a coordinate source and one display driver.
interface seg7_bin_display_if #(
  parameter int unsigned WIDTH  = 9,
  parameter int unsigned DIGITS = 3
) ();
  logic [WIDTH-1:0]    value;
  logic                load;
  logic                busy;
  logic                done;
  logic [7*DIGITS-1:0] hex_out;

  modport master (output value, load, input busy, done, hex_out);
  modport slave  (input value, load, output busy, done, hex_out);
endinterface

// File: rtl/seg7_digit.sv
// Combinational BCD nibble to active-low 7-segment pattern.
module seg7_digit
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    case (nibble)
      4'd0: seg_c = SEG_0;
      4'd1: seg_c = SEG_1;
      4'd2: seg_c = SEG_2;
      4'd3: seg_c = SEG_3;
      4'd4: seg_c = SEG_4;
      4'd5: seg_c = SEG_5;
      4'd6: seg_c = SEG_6;
      4'd7: seg_c = SEG_7;
      4'd8: seg_c = SEG_8;
      4'd9: seg_c = SEG_9;
      default: seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_bin_display.sv
// Iterative binary-to-decimal HEX driver: double-dabble over WIDTH cycles,
// then one latch cycle that updates all digits at once.
module seg7_bin_display
  import seg7_pkg::*;
#(
  parameter int unsigned WIDTH      = 9,
  parameter int unsigned DIGITS     = 3,
  parameter bit          LEAD_BLANK = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  seg7_bin_display_if.slave bus
);

  localparam int unsigned     BCD_W     = 4 * DIGITS;
  localparam int unsigned     HEX_W     = 7 * DIGITS;
  localparam int unsigned     CNT_W     = $clog2(WIDTH + 1);
  localparam longint unsigned OVF_BOUND = pow10(DIGITS);

  seg7_state_e      state, state_next;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [HEX_W-1:0] hex_q, hex_d, hex_disp;
  logic             busy_q, done_q;
  logic             lead_seen;
  logic [6:0]       seg_raw [DIGITS];

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    seg7_digit u_digit (
      .nibble (bcd_q[4*k +: 4]),
      .seg_c  (seg_raw[k])
    );
  end

  // Add-3 correction applied before each shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < DIGITS; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
    end
  end

  // Overflow dashes, then leading-zero blanking scanned from the top digit
  always_comb begin
    hex_disp  = '1;
    lead_seen = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (ovf_q) begin
        hex_disp[7*k +: 7] = SEG_DASH;
      end else if (LEAD_BLANK && (k != 0) && !lead_seen && (bcd_q[4*k +: 4] == 4'd0)) begin
        hex_disp[7*k +: 7] = SEG_BLANK;
      end else begin
        hex_disp[7*k +: 7] = seg_raw[k];
        lead_seen          = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    hex_d      = hex_q;
    case (state)
      IDLE: begin
        if (bus.load) begin
          shift_d    = bus.value;
          bcd_d      = '0;
          cnt_d      = CNT_W'(WIDTH);
          ovf_d      = (64'(bus.value) >= OVF_BOUND);
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
        cnt_d            = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_next = LATCH;
      end
      LATCH: begin
        hex_d      = hex_disp;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      hex_q   <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_next;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      hex_q   <= hex_d;
      busy_q  <= (state_next != IDLE);
      done_q  <= (state == LATCH);
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.hex_out = hex_q;

endmodule

// File: tb/tb_seg7_bin_display.sv
// Bench for seg7_bin_display: three configurations, scoreboard of expected
// hex_out words popped on each done pulse.
module tb_seg7_bin_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0011000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SB = 7'b1111111;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          sel;
    logic [20:0] exp;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    int          sel;
    int unsigned val;
    logic [20:0] exp;
  } vec_t;
  vec_t vecs[13];

  // dut0: defaults; dut1: LEAD_BLANK=0; dut2: DIGITS=2
  seg7_bin_display_if #(.WIDTH(9), .DIGITS(3)) bus0 ();
  seg7_bin_display_if #(.WIDTH(9), .DIGITS(3)) bus1 ();
  seg7_bin_display_if #(.WIDTH(9), .DIGITS(2)) bus2 ();

  seg7_bin_display #(.WIDTH(9), .DIGITS(3), .LEAD_BLANK(1'b1)) dut0 (
    .clk(clk), .resetn(resetn), .bus(bus0));
  seg7_bin_display #(.WIDTH(9), .DIGITS(3), .LEAD_BLANK(1'b0)) dut1 (
    .clk(clk), .resetn(resetn), .bus(bus1));
  seg7_bin_display #(.WIDTH(9), .DIGITS(2), .LEAD_BLANK(1'b1)) dut2 (
    .clk(clk), .resetn(resetn), .bus(bus2));

  function automatic logic [20:0] get_hex(input int sel);
    case (sel)
      0:       return bus0.hex_out;
      1:       return bus1.hex_out;
      default: return {7'h00, bus2.hex_out};
    endcase
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      0:       return bus0.done;
      1:       return bus1.done;
      default: return bus2.done;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return bus0.busy;
      1:       return bus1.busy;
      default: return bus2.busy;
    endcase
  endfunction

  // Reference: arithmetic digit split, blanking, overflow dashes
  function automatic logic [20:0] model(input int sel, input int unsigned v);
    int unsigned nd;
    bit          lb;
    int unsigned p;
    int unsigned t;
    int unsigned dg [3];
    logic [6:0]  segs [10];
    logic [20:0] r;
    bit          seen;
    nd   = (sel == 2) ? 2 : 3;
    lb   = (sel != 1);
    segs = '{S0, S1, S2, S3, S4, S5, S6, S7, S8, S9};
    r    = '0;
    seen = 1'b0;
    p    = 1;
    for (int i = 0; i < int'(nd); i++) p = p * 10;
    t = v;
    for (int k = 0; k < 3; k++) begin
      dg[k] = t % 10;
      t     = t / 10;
    end
    if (v >= p) begin
      for (int k = 0; k < int'(nd); k++) r[7*k +: 7] = SD;
    end else begin
      for (int k = int'(nd) - 1; k >= 0; k--) begin
        if (lb && k != 0 && !seen && dg[k] == 0) r[7*k +: 7] = SB;
        else begin
          r[7*k +: 7] = segs[dg[k]];
          seen = 1'b1;
        end
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [20:0] act, input logic [20:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (get_done(s)) begin
        sb_t e;
        checks++;
        if (get_busy(s)) begin
          failures++;
          $display("FAIL done_with_busy dut=%0d actual=busy1 required=busy0", s);
        end
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done dut=%0d actual=done required=no_done", s);
        end else begin
          e = sbq.pop_front();
          if (e.sel != s || get_hex(s) !== e.exp) begin
            failures++;
            $display("FAIL hex_out dut=%0d actual=%h required=%h (dut %0d)",
                     s, get_hex(s), e.exp, e.sel);
          end
        end
      end
    end
  end

  task automatic do_load(input int sel, input int unsigned v);
    @(negedge clk);
    case (sel)
      0:       begin bus0.value = 9'(v); bus0.load = 1'b1; end
      1:       begin bus1.value = 9'(v); bus1.load = 1'b1; end
      default: begin bus2.value = 9'(v); bus2.load = 1'b1; end
    endcase
    @(negedge clk);
    bus0.load = 1'b0;
    bus1.load = 1'b0;
    bus2.load = 1'b0;
  endtask

  task automatic issue(input int sel, input int unsigned v, input logic [20:0] exp);
    sbq.push_back('{sel, exp});
    do_load(sel, v);
  endtask

  task automatic wait_drain(output int cyc);
    cyc = 0;
    while (sbq.size() != 0 && cyc < 60) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL done_timeout actual=%0d_pending required=0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          cyc;
    int          busy_cnt;
    bit          stable;
    logic [20:0] snap [3];
    logic [20:0] ones;
    int unsigned v;

    resetn = 1'b0;
    bus0.value = '0; bus0.load = 1'b0;
    bus1.value = '0; bus1.load = 1'b0;
    bus2.value = '0; bus2.load = 1'b0;

    vecs[0]  = '{0, 305, {S3, S0, S5}};
    vecs[1]  = '{0,   7, {SB, SB, S7}};
    vecs[2]  = '{0,   0, {SB, SB, S0}};
    vecs[3]  = '{0, 511, {S5, S1, S1}};
    vecs[4]  = '{0, 100, {S1, S0, S0}};
    vecs[5]  = '{0,  10, {SB, S1, S0}};
    vecs[6]  = '{1,   7, {S0, S0, S7}};
    vecs[7]  = '{1,   0, {S0, S0, S0}};
    vecs[8]  = '{2, 100, {7'h00, SD, SD}};
    vecs[9]  = '{2,  99, {7'h00, S9, S9}};
    vecs[10] = '{2, 511, {7'h00, SD, SD}};
    vecs[11] = '{2,   5, {7'h00, SB, S5}};
    vecs[12] = '{1, 468, {S4, S6, S8}};

    // Reset state
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      ones = (s == 2) ? 21'h003FFF : 21'h1FFFFF;
      chk($sformatf("reset_hex_dut%0d", s), get_hex(s), ones);
      chk($sformatf("reset_busy_dut%0d", s), 21'(get_busy(s)), 21'd0);
      chk($sformatf("reset_done_dut%0d", s), 21'(get_done(s)), 21'd0);
    end
    resetn = 1'b1;
    for (int s = 0; s < 3; s++) snap[s] = get_hex(s);
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++)
        if (get_hex(s) !== snap[s] || get_busy(s) || get_done(s)) stable = 1'b0;
    end
    chk("idle_outputs_stable", 21'(stable), 21'd1);

    // Busy window and done pulse timing for 305
    issue(0, 305, {S3, S0, S5});
    busy_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus0.busy && !bus0.done) busy_cnt++;
      @(negedge clk);
    end
    chk("busy_cycles", 21'(busy_cnt), 21'd10);
    chk("done_at_cycle11", 21'(bus0.done), 21'd1);
    chk("busy_low_at_done", 21'(bus0.busy), 21'd0);
    @(negedge clk);
    chk("done_one_cycle", 21'(bus0.done), 21'd0);

    // Table vectors
    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].sel, vecs[i].val, vecs[i].exp);
      wait_drain(cyc);
      chk($sformatf("latency_vec%0d", i), 21'(cyc), 21'd10);
    end

    // Random values against the arithmetic model
    for (int s = 0; s < 3; s++) begin
      for (int j = 0; j < 8; j++) begin
        v = $urandom_range(0, 511);
        issue(s, v, model(s, v));
        wait_drain(cyc);
        chk($sformatf("latency_rand_dut%0d_v%0d", s, v), 21'(cyc), 21'd10);
      end
    end

    // Load while busy is dropped
    issue(0, 123, {S1, S2, S3});
    repeat (2) @(negedge clk);
    do_load(0, 45);
    wait_drain(cyc);
    repeat (25) @(negedge clk);
    issue(0, 45, {SB, S4, S5});
    wait_drain(cyc);
    chk("latency_fresh_45", 21'(cyc), 21'd10);

    // Reset in the middle of a conversion
    do_load(0, 300);
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("midreset_hex", bus0.hex_out, 21'h1FFFFF);
    chk("midreset_busy", 21'(bus0.busy), 21'd0);
    stable = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus0.done || bus0.busy) stable = 1'b0;
    end
    chk("midreset_quiet", 21'(stable), 21'd1);
    resetn = 1'b1;
    repeat (15) @(negedge clk);
    chk("post_reset_hex", bus0.hex_out, 21'h1FFFFF);
    issue(0, 42, {SB, S4, S2});
    wait_drain(cyc);
    chk("latency_after_reset", 21'(cyc), 21'd10);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
